scoreboard_issuer: RTL and testbench
====================================

# scoreboard_issuer

Initiator side of the scoreboard write interface. Accepts dispatched instructions from upstream, allocates scoreboard entries in circular order, forwards completion reports from execution, and retires entries in program order. It drives the scoreboard's single-index write port with at most one operation per cycle, and supports a flush that invalidates every live entry.

## Interface
- SCRBRD_SIZE, 32, number of entries; power of two, ≥2; IDX_W = $clog2(SCRBRD_SIZE)
- PC_WIDTH, 32, PC width
- OPCODE_WIDTH, 5, opcode width
- clk  in  1  clock; all logic on posedge
- rst  in  1  one clock; reset is synchronous and active-low (rst==0 resets on the clock edge)
- disp_vld / disp_rdy  in / out  1 / 1  dispatch handshake; transfer when both high
- disp_pc  in  PC_WIDTH  PC of dispatched instruction
- disp_opcode  in  OPCODE_WIDTH  opcode of dispatched instruction
- disp_idx  out  IDX_W  index allocated to the current dispatch (= tail, combinational)
- cmpl_vld / cmpl_rdy  in / out  1 / 1  completion handshake
- cmpl_idx  in  IDX_W  index reported complete
- flush  in  1  level request; start invalidating all live entries
- retire_vld  out  1  registered pulse; head entry retired in order
- retire_idx  out  IDX_W  index retired, valid with retire_vld
- cmpl_err  out  1  registered pulse; accepted completion targeted a non-live or already-done entry
- sb_idx  out  IDX_W  scoreboard write index
- sb_pc_vld / sb_pc  out  1 / PC_WIDTH  PC write; also marks entry valid at the scoreboard
- sb_opcode_vld / sb_opcode  out  1 / OPCODE_WIDTH  opcode write
- sb_completed_vld  out  1  mark entry completed
- sb_invalidate_vld  out  1  clear entry valid
- count  out  IDX_W+1  live entries
- full / empty  out  1 / 1  count==SCRBRD_SIZE / count==0

## Operation
- State: head, tail (IDX_W, wrap mod SCRBRD_SIZE), count, done[SCRBRD_SIZE], FSM {RUN, FLUSH}.
- Live entry i: lies in the circular range [head, head+count).
- RUN, one op selected per cycle, priority high→low:
  1. Retire: count>0 && done[head]. Drive invalidate on head, pulse retire_vld/retire_idx=head, head++, count--, clear done[head].
  2. Completion: cmpl_rdy = no retire this cycle. On accept, if idx is live and !done, set done[idx] and drive sb_completed_vld. Otherwise drive no write and pulse cmpl_err.
  3. Allocate: disp_rdy = !full && no retire && !cmpl_vld && !flush. On transfer, drive sb_pc_vld=sb_opcode_vld=1 with disp_pc/disp_opcode at idx=tail, clear done[tail], tail++, count++.
- flush sampled in RUN → FLUSH on the next edge. Flush beats retire and alloc for that cycle: no op in the sampling cycle.
- FLUSH: disp_rdy=cmpl_rdy=0. Each cycle with count>0, drive invalidate on head, head++, count--, no retire_vld. When count==0, go to RUN; head==tail retained, done cleared.
- Every sb_* and retire/err output is registered from the selected op. Each *_vld is high for exactly one cycle per op. Data fields hold their last value when invalid.

## Timing
- Handshake at edge N → sb_* write visible in cycle N+1. Pointer and count updates take effect at edge N.
- Completion accepted at N → done set at N. Earliest retire of that entry is selected in cycle N+1 and appears on sb_* at N+2.
- Simultaneous cmpl_vld and disp_vld: completion wins, dispatch stalls.
- Full: disp_rdy=0. A retire in the same cycle does not unblock dispatch until the next cycle.
- Wrap: tail SCRBRD_SIZE-1 → 0 with no gap.
- Reset: every output 0 except empty=1 and disp_rdy=1 once rst deasserts. head=tail=count=0, done=0, state RUN. Reset mid-flush aborts the flush with no further invalidates.

## Structure
- Shared package scoreboard_pkg: SCRBRD_SIZE, PC_WIDTH, OPCODE_WIDTH defaults, IDX_W, a state enum {RUN, FLUSH}, an op-select enum {OP_NONE, OP_RETIRE, OP_CMPL, OP_ALLOC, OP_FLUSH_INV}.
- One sub-module: scoreboard_issuer_ptr. It holds the head/tail/count circular pointer logic and live-range check, and exposes full, empty, and is_live(idx).

## Test plan
- Reset, then 3 dispatches (pc 0x100/0x104/0x108) → sb_pc_vld on idx 0,1,2 one cycle after each transfer; count=3.
- Complete idx 1 then idx 0 → no retire after idx 1 alone. After idx 0: retires 0 and then 1 on consecutive cycles, each with sb_invalidate_vld; count=1.
- Fill 32 entries → full=1, disp_rdy=0. Complete and retire head → tail wraps, next alloc at idx 0.
- cmpl_vld and disp_vld in the same cycle → completion accepted, dispatch accepted the following cycle. Complete a non-live idx 5 → cmpl_err pulse, no sb write.
- flush with 4 live entries at head=30 → invalidates 30,31,0,1 on consecutive cycles, no retire_vld, then RUN with empty=1.
- rst low during FLUSH → all outputs 0 next cycle, count=0.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared constants and enumerations for the scoreboard issuer.
// The top and pointer modules are parameterised; these are their defaults.
package scoreboard_pkg;

  localparam int DEF_SCRBRD_SIZE  = 32;
  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_OPCODE_WIDTH = 5;
  localparam int DEF_IDX_W        = $clog2(DEF_SCRBRD_SIZE);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE      = 3'd0,
    OP_RETIRE    = 3'd1,
    OP_CMPL      = 3'd2,
    OP_ALLOC     = 3'd3,
    OP_FLUSH_INV = 3'd4
  } op_e;

endpackage

// File: rtl/scoreboard_issuer_ptr.sv
// Circular head/tail/count bookkeeping for the scoreboard, plus a live-range
// test for one index against the window [head, head+count).
module scoreboard_issuer_ptr
  import scoreboard_pkg::*;
#(
  parameter int SIZE = DEF_SCRBRD_SIZE,
  localparam int IW  = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_head,
  input  logic          inc_tail,
  input  logic [IW-1:0] chk_idx,
  output logic [IW-1:0] head,
  output logic [IW-1:0] tail,
  output logic [IW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          chk_live
);

  logic [IW-1:0] head_r;
  logic [IW-1:0] tail_r;
  logic [IW:0]   count_r;
  logic [IW-1:0] offset_s;

  // Pointers wrap naturally because SIZE is a power of two
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (inc_head) head_r <= head_r + IW'(1);
      if (inc_tail) tail_r <= tail_r + IW'(1);
      count_r <= count_r + (IW+1)'(inc_tail) - (IW+1)'(inc_head);
    end
  end

  assign offset_s = chk_idx - head_r;
  assign chk_live = ({1'b0, offset_s} < count_r);
  assign head     = head_r;
  assign tail     = tail_r;
  assign count    = count_r;
  assign full     = (count_r == (IW+1)'(SIZE));
  assign empty    = (count_r == '0);

endmodule

// File: rtl/scoreboard_issuer.sv
// Scoreboard write-port initiator: allocates entries in circular order, records
// completions, retires in program order and flushes all live entries on request.
module scoreboard_issuer
  import scoreboard_pkg::*;
#(
  parameter int SCRBRD_SIZE  = DEF_SCRBRD_SIZE,
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  localparam int IDX_W       = $clog2(SCRBRD_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    disp_vld,
  output logic                    disp_rdy,
  input  logic [PC_WIDTH-1:0]     disp_pc,
  input  logic [OPCODE_WIDTH-1:0] disp_opcode,
  output logic [IDX_W-1:0]        disp_idx,
  input  logic                    cmpl_vld,
  output logic                    cmpl_rdy,
  input  logic [IDX_W-1:0]        cmpl_idx,
  input  logic                    flush,
  output logic                    retire_vld,
  output logic [IDX_W-1:0]        retire_idx,
  output logic                    cmpl_err,
  output logic [IDX_W-1:0]        sb_idx,
  output logic                    sb_pc_vld,
  output logic [PC_WIDTH-1:0]     sb_pc,
  output logic                    sb_opcode_vld,
  output logic [OPCODE_WIDTH-1:0] sb_opcode,
  output logic                    sb_completed_vld,
  output logic                    sb_invalidate_vld,
  output logic [IDX_W:0]          count,
  output logic                    full,
  output logic                    empty
);

  state_e                  state_r, state_nx_s;
  op_e                     op_s;
  logic [SCRBRD_SIZE-1:0]  done_r;
  logic [IDX_W-1:0]        head_s, tail_s;
  logic                    full_s, empty_s, cmpl_live_s;
  logic                    retire_s, cmpl_err_s, disp_rdy_s, cmpl_rdy_s;
  logic                    inc_head_s, inc_tail_s;

  logic [IDX_W-1:0]        sb_idx_r, retire_idx_r;
  logic [PC_WIDTH-1:0]     sb_pc_r;
  logic [OPCODE_WIDTH-1:0] sb_opcode_r;
  logic                    sb_pc_vld_r, sb_opcode_vld_r, sb_completed_vld_r;
  logic                    sb_invalidate_vld_r, retire_vld_r, cmpl_err_r;

  scoreboard_issuer_ptr #(.SIZE(SCRBRD_SIZE)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .inc_head (inc_head_s),
    .inc_tail (inc_tail_s),
    .chk_idx  (cmpl_idx),
    .head     (head_s),
    .tail     (tail_s),
    .count    (count),
    .full     (full_s),
    .empty    (empty_s),
    .chk_live (cmpl_live_s)
  );

  assign retire_s   = !empty_s && done_r[head_s];
  assign inc_head_s = (op_s == OP_RETIRE) || (op_s == OP_FLUSH_INV);
  assign inc_tail_s = (op_s == OP_ALLOC);

  // Operation select; a sampled flush suppresses every op in that cycle
  always_comb begin
    op_s       = OP_NONE;
    state_nx_s = state_r;
    cmpl_err_s = 1'b0;
    disp_rdy_s = 1'b0;
    cmpl_rdy_s = 1'b0;
    case (state_r)
      RUN: begin
        if (flush) begin
          state_nx_s = FLUSH;
        end else begin
          cmpl_rdy_s = !retire_s;
          disp_rdy_s = !full_s && !retire_s && !cmpl_vld;
          if (retire_s) begin
            op_s = OP_RETIRE;
          end else if (cmpl_vld) begin
            if (cmpl_live_s && !done_r[cmpl_idx]) op_s = OP_CMPL;
            else cmpl_err_s = 1'b1;
          end else if (disp_vld && disp_rdy_s) begin
            op_s = OP_ALLOC;
          end else begin
            op_s = OP_NONE;
          end
        end
      end
      FLUSH: begin
        if (!empty_s) op_s = OP_FLUSH_INV;
        else state_nx_s = RUN;
      end
      default: state_nx_s = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state_r <= RUN;
    else      state_r <= state_nx_s;
  end

  // Per-entry completion flags; wiped while flushing
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_r <= '0;
    end else if (state_r == FLUSH) begin
      done_r <= '0;
    end else begin
      case (op_s)
        OP_RETIRE: done_r[head_s]   <= 1'b0;
        OP_CMPL:   done_r[cmpl_idx] <= 1'b1;
        OP_ALLOC:  done_r[tail_s]   <= 1'b0;
        default:   done_r <= done_r;
      endcase
    end
  end

  // Registered write port; data fields hold their last value between ops
  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_idx_r            <= '0;
      sb_pc_r             <= '0;
      sb_opcode_r         <= '0;
      retire_idx_r        <= '0;
      sb_pc_vld_r         <= 1'b0;
      sb_opcode_vld_r     <= 1'b0;
      sb_completed_vld_r  <= 1'b0;
      sb_invalidate_vld_r <= 1'b0;
      retire_vld_r        <= 1'b0;
      cmpl_err_r          <= 1'b0;
    end else begin
      sb_pc_vld_r         <= (op_s == OP_ALLOC);
      sb_opcode_vld_r     <= (op_s == OP_ALLOC);
      sb_completed_vld_r  <= (op_s == OP_CMPL);
      sb_invalidate_vld_r <= inc_head_s;
      retire_vld_r        <= (op_s == OP_RETIRE);
      cmpl_err_r          <= cmpl_err_s;
      case (op_s)
        OP_ALLOC: begin
          sb_idx_r    <= tail_s;
          sb_pc_r     <= disp_pc;
          sb_opcode_r <= disp_opcode;
        end
        OP_CMPL:      sb_idx_r <= cmpl_idx;
        OP_RETIRE: begin
          sb_idx_r     <= head_s;
          retire_idx_r <= head_s;
        end
        OP_FLUSH_INV: sb_idx_r <= head_s;
        default:      sb_idx_r <= sb_idx_r;
      endcase
    end
  end

  assign disp_rdy          = disp_rdy_s;
  assign cmpl_rdy          = cmpl_rdy_s;
  assign disp_idx          = tail_s;
  assign full              = full_s;
  assign empty             = empty_s;
  assign sb_idx            = sb_idx_r;
  assign sb_pc             = sb_pc_r;
  assign sb_opcode         = sb_opcode_r;
  assign sb_pc_vld         = sb_pc_vld_r;
  assign sb_opcode_vld     = sb_opcode_vld_r;
  assign sb_completed_vld  = sb_completed_vld_r;
  assign sb_invalidate_vld = sb_invalidate_vld_r;
  assign retire_vld        = retire_vld_r;
  assign retire_idx        = retire_idx_r;
  assign cmpl_err          = cmpl_err_r;

endmodule

// File: tb/tb_scoreboard_issuer.sv
// Directed self-checking bench for scoreboard_issuer with hand-computed
// expectations: allocate, complete, in-order retire, wrap, full, flush, reset.
module tb_scoreboard_issuer;

  logic        clk;
  logic        rst;
  logic        disp_vld, disp_rdy;
  logic [31:0] disp_pc;
  logic [4:0]  disp_opcode;
  logic [4:0]  disp_idx;
  logic        cmpl_vld, cmpl_rdy;
  logic [4:0]  cmpl_idx;
  logic        flush;
  logic        retire_vld;
  logic [4:0]  retire_idx;
  logic        cmpl_err;
  logic [4:0]  sb_idx;
  logic        sb_pc_vld;
  logic [31:0] sb_pc;
  logic        sb_opcode_vld;
  logic [4:0]  sb_opcode;
  logic        sb_completed_vld, sb_invalidate_vld;
  logic [5:0]  count;
  logic        full, empty;

  int errors = 0;
  int checks = 0;

  scoreboard_issuer dut (
    .clk(clk), .rst(rst),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_pc(disp_pc),
    .disp_opcode(disp_opcode), .disp_idx(disp_idx),
    .cmpl_vld(cmpl_vld), .cmpl_rdy(cmpl_rdy), .cmpl_idx(cmpl_idx),
    .flush(flush), .retire_vld(retire_vld), .retire_idx(retire_idx),
    .cmpl_err(cmpl_err), .sb_idx(sb_idx), .sb_pc_vld(sb_pc_vld), .sb_pc(sb_pc),
    .sb_opcode_vld(sb_opcode_vld), .sb_opcode(sb_opcode),
    .sb_completed_vld(sb_completed_vld), .sb_invalidate_vld(sb_invalidate_vld),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; disp_vld = 1'b0; disp_pc = 32'h0; disp_opcode = 5'h0;
    cmpl_vld = 1'b0; cmpl_idx = 5'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_disp_rdy", disp_rdy, 1);
    chk("rst_pc_vld", sb_pc_vld, 0);
    chk("rst_retire", retire_vld, 0);
    chk("rst_sb_idx", sb_idx, 0);

    // three back-to-back dispatches at idx 0,1,2
    for (int i = 0; i < 3; i++) begin
      disp_vld = 1'b1; disp_pc = 32'h100 + 32'(4 * i); disp_opcode = 5'(i + 1);
      #1 chk("disp_idx", disp_idx, i);
      step();
      chk("alloc_vld", sb_pc_vld, 1);
      chk("alloc_op_vld", sb_opcode_vld, 1);
      chk("alloc_idx", sb_idx, i);
      chk("alloc_pc", sb_pc, 32'h100 + 32'(4 * i));
      chk("alloc_opc", sb_opcode, i + 1);
    end
    disp_vld = 1'b0;
    step();
    chk("alloc_pulse", sb_pc_vld, 0);
    chk("count3", count, 3);

    // complete 1 alone: no retire; then 0: retire 0 and 1 back to back
    cmpl_vld = 1'b1; cmpl_idx = 5'd1;
    #1 chk("cmpl_rdy", cmpl_rdy, 1);
    step(); cmpl_vld = 1'b0;
    chk("cmpl1_vld", sb_completed_vld, 1);
    chk("cmpl1_idx", sb_idx, 1);
    chk("cmpl1_err", cmpl_err, 0);
    step();
    chk("no_early_retire", retire_vld, 0);
    chk("cmpl_pulse", sb_completed_vld, 0);
    cmpl_vld = 1'b1; cmpl_idx = 5'd0;
    step(); cmpl_vld = 1'b0;
    chk("cmpl0_idx", sb_idx, 0);
    step();
    chk("ret0_vld", retire_vld, 1);
    chk("ret0_idx", retire_idx, 0);
    chk("ret0_inv", sb_invalidate_vld, 1);
    chk("ret0_sbidx", sb_idx, 0);
    step();
    chk("ret1_vld", retire_vld, 1);
    chk("ret1_idx", retire_idx, 1);
    chk("ret1_inv", sb_invalidate_vld, 1);
    chk("count1", count, 1);
    step();
    chk("ret_pulse", retire_vld, 0);

    // head=2; allocate idx 3, then completion and dispatch together
    disp_vld = 1'b1; disp_pc = 32'h10C; disp_opcode = 5'd4;
    step(); disp_vld = 1'b0;
    chk("alloc3_idx", sb_idx, 3);
    cmpl_vld = 1'b1; cmpl_idx = 5'd3;
    disp_vld = 1'b1; disp_pc = 32'h200; disp_opcode = 5'd7;
    #1 chk("coll_disp_rdy", disp_rdy, 0);
    chk("coll_cmpl_rdy", cmpl_rdy, 1);
    step(); cmpl_vld = 1'b0;
    chk("coll_cmpl", sb_completed_vld, 1);
    chk("coll_cmpl_idx", sb_idx, 3);
    chk("coll_no_alloc", sb_pc_vld, 0);
    #1 chk("coll_disp_rdy2", disp_rdy, 1);
    chk("coll_disp_idx", disp_idx, 4);
    step(); disp_vld = 1'b0;
    chk("coll_alloc", sb_pc_vld, 1);
    chk("coll_alloc_idx", sb_idx, 4);
    chk("coll_alloc_pc", sb_pc, 32'h200);
    chk("count3b", count, 3);

    // error completions: non-live 5 and already-done 3
    cmpl_vld = 1'b1; cmpl_idx = 5'd5;
    step(); cmpl_vld = 1'b0;
    chk("err5", cmpl_err, 1);
    chk("err5_nowr", sb_completed_vld, 0);
    chk("err5_sbidx", sb_idx, 4);
    step();
    chk("err_pulse", cmpl_err, 0);
    cmpl_vld = 1'b1; cmpl_idx = 5'd3;
    step(); cmpl_vld = 1'b0;
    chk("err_done", cmpl_err, 1);
    chk("err_done_nowr", sb_completed_vld, 0);

    // complete 2 -> retires 2 then 3; head stops at not-done 4
    cmpl_vld = 1'b1; cmpl_idx = 5'd2;
    step(); cmpl_vld = 1'b0;
    step();
    chk("ret2_idx", retire_idx, 2);
    step();
    chk("ret3_vld", retire_vld, 1);
    chk("ret3_idx", retire_idx, 3);
    step();
    chk("ret_stop", retire_vld, 0);
    chk("count1b", count, 1);

    // allocate idx 5..29, complete out of order, then drain 4..29 in order
    for (int k = 0; k < 25; k++) begin
      disp_vld = 1'b1; disp_pc = 32'h300 + 32'(k); disp_opcode = 5'd1;
      step();
      chk("fill25_idx", sb_idx, 5 + k);
    end
    disp_vld = 1'b0;
    for (int k = 5; k < 30; k++) begin
      cmpl_vld = 1'b1; cmpl_idx = 5'(k);
      step();
      chk("ooo_cmpl_idx", sb_idx, k);
      chk("ooo_no_retire", retire_vld, 0);
    end
    cmpl_idx = 5'd4;
    step(); cmpl_vld = 1'b0;
    for (int j = 0; j < 26; j++) begin
      step();
      chk("drain_vld", retire_vld, 1);
      chk("drain_idx", retire_idx, 4 + j);
    end
    chk("drain_empty", empty, 1);

    // four entries at 30,31,0,1 (tail wraps), then flush them
    for (int k = 0; k < 4; k++) begin
      disp_vld = 1'b1; disp_pc = 32'h400 + 32'(k); disp_opcode = 5'd2;
      step();
      chk("wrap_idx", sb_idx, (30 + k) % 32);
    end
    disp_vld = 1'b0;
    chk("count4", count, 4);
    flush = 1'b1;
    step(); flush = 1'b0;
    chk("flush_sample_noop", sb_invalidate_vld, 0);
    chk("flush_disp_rdy", disp_rdy, 0);
    chk("flush_cmpl_rdy", cmpl_rdy, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("flush_inv", sb_invalidate_vld, 1);
      chk("flush_idx", sb_idx, (30 + k) % 32);
      chk("flush_no_ret", retire_vld, 0);
    end
    step();
    chk("flush_end_inv", sb_invalidate_vld, 0);
    chk("flush_empty", empty, 1);
    chk("flush_run_rdy", disp_rdy, 1);
    chk("flush_tail", disp_idx, 2);

    // fill all 32 from idx 2; a same-cycle retire does not unblock dispatch
    for (int k = 0; k < 32; k++) begin
      disp_vld = 1'b1; disp_pc = 32'h1000 + 32'(k); disp_opcode = 5'd3;
      step();
      chk("fill_idx", sb_idx, (2 + k) % 32);
    end
    chk("full", full, 1);
    chk("full_rdy", disp_rdy, 0);
    chk("full_count", count, 32);
    cmpl_vld = 1'b1; cmpl_idx = 5'd2;
    step(); cmpl_vld = 1'b0;
    chk("full_cmpl", sb_completed_vld, 1);
    #1 chk("retire_blocks_disp", disp_rdy, 0);
    step();
    chk("full_ret_idx", retire_idx, 2);
    chk("full_drop", full, 0);
    #1 chk("unblock_rdy", disp_rdy, 1);
    chk("unblock_idx", disp_idx, 2);
    step(); disp_vld = 1'b0;
    chk("refill_vld", sb_pc_vld, 1);
    chk("refill_idx", sb_idx, 2);
    chk("refill_full", full, 1);

    // reset while flushing aborts the flush
    flush = 1'b1;
    step(); flush = 1'b0;
    step();
    chk("mid_inv0", sb_idx, 3);
    step();
    chk("mid_inv1", sb_idx, 4);
    chk("mid_inv_vld", sb_invalidate_vld, 1);
    rst = 1'b0;
    step();
    chk("rst_mid_inv", sb_invalidate_vld, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_sbidx", sb_idx, 0);
    chk("rst_mid_pc", sb_pc, 0);
    chk("rst_mid_empty", empty, 1);
    rst = 1'b1;
    step();
    chk("post_rst_inv", sb_invalidate_vld, 0);
    chk("post_rst_rdy", disp_rdy, 1);
    chk("post_rst_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
